// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : DEPTH-deep inter-stage pipeline register (valid/ctrl/data) with
//            stall, flush and kill, plus a registered occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              kill_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  occ_o
);

    localparam logic [CNT_W-1:0] c_occ_max = CNT_W'(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]             occ_q,   occ_d;
    logic                         w_in_valid;
    logic                         w_out_valid;

    assign w_in_valid  = valid_i & ~flush_i;
    assign w_out_valid = valid_q[DEPTH-1];

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        occ_d   = occ_q;
        if (kill_i) begin
            // Data is left in place; only the fields that can cause side effects are cleared.
            valid_d = '0;
            ctrl_d  = '0;
            occ_d   = '0;
        end else if (!stall_i) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                valid_d[s] = valid_q[s-1];
                ctrl_d[s]  = ctrl_q[s-1];
                data_d[s]  = data_q[s-1];
            end
            valid_d[0] = w_in_valid;
            ctrl_d[0]  = w_in_valid ? ctrl_i : '0;
            data_d[0]  = data_i;
            if (w_in_valid && !w_out_valid && (occ_q != c_occ_max)) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (!w_in_valid && w_out_valid && (occ_q != '0)) begin
                occ_d = occ_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign ctrl_o  = ctrl_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
    assign occ_o   = occ_q;

    a_occ_popcount : assert property (@(posedge clk_i) disable iff (!rst_i)
        occ_q == CNT_W'($countones(valid_q)));

    for (genvar s = 0; s < DEPTH; s++) begin : g_ctrl_gate
        a_ctrl_gated : assert property (@(posedge clk_i) disable iff (!rst_i)
            !valid_q[s] |-> (ctrl_q[s] == '0));
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg at DEPTH 1, 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, kill, vin;
    logic [CW-1:0] cin;
    logic [DW-1:0] din;

    logic          v1, v2, v4;
    logic [CW-1:0] c1, c2, c4;
    logic [DW-1:0] d1, d2, d4;
    logic [0:0]    o1;
    logic [1:0]    o2;
    logic [2:0]    o4;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1)) u_d1 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .kill_i(kill),
        .valid_i(vin), .ctrl_i(cin), .data_i(din),
        .valid_o(v1), .ctrl_o(c1), .data_o(d1), .occ_o(o1));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .kill_i(kill),
        .valid_i(vin), .ctrl_i(cin), .data_i(din),
        .valid_o(v2), .ctrl_o(c2), .data_o(d2), .occ_o(o2));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .kill_i(kill),
        .valid_i(vin), .ctrl_i(cin), .data_i(din),
        .valid_o(v4), .ctrl_o(c4), .data_o(d4), .occ_o(o4));

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    typedef struct {
        bit            rst_n, kill, stall, flush, v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        bit            ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        int            eo;
    } vec_t;

    entry_t        mdl [3][4];
    int            dep [3] = '{1, 2, 4};
    logic          got_v [3];
    logic [CW-1:0] got_c [3];
    logic [DW-1:0] got_d [3];
    int            got_o [3];

    assign got_v[0] = v1;  assign got_c[0] = c1;  assign got_d[0] = d1;  assign got_o[0] = int'(o1);
    assign got_v[1] = v2;  assign got_c[1] = c2;  assign got_d[1] = d2;  assign got_o[1] = int'(o2);
    assign got_v[2] = v4;  assign got_c[2] = c4;  assign got_d[2] = d4;  assign got_o[2] = int'(o4);

    int   tests = 0;
    int   fails = 0;
    int   max_o4 = 0;
    vec_t tbl [20];

    function automatic vec_t vec(bit r, bit k, bit s, bit f, bit v, logic [CW-1:0] c,
                                 logic [DW-1:0] d, bit ev, logic [CW-1:0] ec,
                                 logic [DW-1:0] ed, int eo);
        vec_t t;
        t.rst_n = r; t.kill = k; t.stall = s; t.flush = f; t.v = v; t.c = c; t.d = d;
        t.ev = ev; t.ec = ec; t.ed = ed; t.eo = eo;
        return t;
    endfunction

    task automatic set_in(bit r, bit k, bit s, bit f, bit v, logic [CW-1:0] c, logic [DW-1:0] d);
        rst_n = r; kill = k; stall = s; flush = f; vin = v; cin = c; din = d;
    endtask

    // Reference: each pipe is a list of DEPTH slots; an advance drops the oldest
    // slot and inserts the new instruction at the front.
    task automatic model_step();
        entry_t nw;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                for (int s = 0; s < 4; s++) mdl[k][s] = '0;
            end else if (kill) begin
                for (int s = 0; s < 4; s++) begin
                    mdl[k][s].v = 1'b0;
                    mdl[k][s].c = '0;
                end
            end else if (!stall) begin
                nw.v = vin && !flush;
                nw.c = nw.v ? cin : '0;
                nw.d = din;
                for (int s = dep[k] - 1; s > 0; s--) mdl[k][s] = mdl[k][s-1];
                mdl[k][0] = nw;
            end
        end
    endtask

    function automatic int model_occ(int k);
        int n = 0;
        for (int s = 0; s < dep[k]; s++) n += int'(mdl[k][s].v);
        return n;
    endfunction

    task automatic check_model(string tag);
        entry_t e;
        for (int k = 0; k < 3; k++) begin
            e = mdl[k][dep[k]-1];
            tests++;
            if (got_v[k] !== e.v || got_c[k] !== e.c || got_d[k] !== e.d ||
                got_o[k] != model_occ(k)) begin
                fails++;
                $display("FAIL %s depth%0d: got v=%b c=%h d=%h occ=%0d, want v=%b c=%h d=%h occ=%0d",
                         tag, dep[k], got_v[k], got_c[k], got_d[k], got_o[k],
                         e.v, e.c, e.d, model_occ(k));
            end
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_step();
        #1;
        if (int'(o4) > max_o4) max_o4 = int'(o4);
        check_model(tag);
    endtask

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 4; s++) mdl[k][s] = '0;
        set_in(0, 0, 0, 0, 0, '0, '0);

        //            rst k s f v  ctrl   data          ev  ectrl  edata         eocc
        tbl[0]  = vec(0, 0,0,0,1, 8'hFF, 32'hDEADBEEF, 0, 8'h00, 32'h0,        0);
        tbl[1]  = vec(0, 0,0,0,1, 8'hFF, 32'hDEADBEEF, 0, 8'h00, 32'h0,        0);
        tbl[2]  = vec(1, 0,0,0,1, 8'h11, 32'hA0,       0, 8'h00, 32'h0,        1);
        tbl[3]  = vec(1, 0,0,0,1, 8'h22, 32'hA1,       1, 8'h11, 32'hA0,       2);
        tbl[4]  = vec(1, 0,1,0,1, 8'h55, 32'hC5,       1, 8'h11, 32'hA0,       2);
        tbl[5]  = vec(1, 0,1,0,0, 8'h66, 32'hC6,       1, 8'h11, 32'hA0,       2);
        tbl[6]  = vec(1, 0,1,0,1, 8'h77, 32'hC7,       1, 8'h11, 32'hA0,       2);
        tbl[7]  = vec(1, 0,0,0,1, 8'h33, 32'hA2,       1, 8'h22, 32'hA1,       2);
        tbl[8]  = vec(1, 0,0,1,1, 8'h44, 32'hB0,       1, 8'h33, 32'hA2,       1);
        tbl[9]  = vec(1, 0,0,0,1, 8'h55, 32'hC0,       0, 8'h00, 32'hB0,       1);
        tbl[10] = vec(1, 0,0,0,1, 8'h66, 32'hC1,       1, 8'h55, 32'hC0,       2);
        tbl[11] = vec(1, 1,1,1,1, 8'h77, 32'hD0,       0, 8'h00, 32'hC0,       0);
        tbl[12] = vec(1, 0,0,0,1, 8'h88, 32'hD1,       0, 8'h00, 32'hC1,       1);
        tbl[13] = vec(1, 0,0,0,1, 8'h99, 32'hD2,       1, 8'h88, 32'hD1,       2);
        tbl[14] = vec(1, 0,1,1,1, 8'hAA, 32'hE0,       1, 8'h88, 32'hD1,       2);
        tbl[15] = vec(1, 0,0,0,0, 8'hBB, 32'hE1,       1, 8'h99, 32'hD2,       1);
        tbl[16] = vec(0, 0,1,0,1, 8'hCC, 32'hE2,       0, 8'h00, 32'h0,        0);
        tbl[17] = vec(1, 0,0,0,1, 8'h12, 32'hF0,       0, 8'h00, 32'h0,        1);
        tbl[18] = vec(1, 0,0,0,0, 8'h34, 32'hF1,       1, 8'h12, 32'hF0,       1);
        tbl[19] = vec(1, 0,0,0,0, 8'h56, 32'hF2,       0, 8'h00, 32'hF1,       0);

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].rst_n, tbl[i].kill, tbl[i].stall, tbl[i].flush, tbl[i].v,
                   tbl[i].c, tbl[i].d);
            step("model_tbl");
            tests++;
            if (v2 !== tbl[i].ev || c2 !== tbl[i].ec || d2 !== tbl[i].ed || int'(o2) != tbl[i].eo) begin
                fails++;
                $display("FAIL vec%0d: got v=%b c=%h d=%h occ=%0d, want v=%b c=%h d=%h occ=%0d",
                         i, v2, c2, d2, o2, tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].eo);
            end
        end

        // Deep-pipe fill, peak occupancy and kill on a full DEPTH=4 chain.
        set_in(0, 0, 0, 0, 0, '0, '0);
        step("seq_reset");
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 1, CW'(8'h40 + i), DW'(100 + i));
            step("seq_fill");
        end
        chk("d4_occ_full", int'(o4), 4);
        chk("d4_first_out", int'(d4), 100);
        chk("d4_valid_lat", int'(v4), 1);
        chk("d1_latency", int'(d1), 103);
        set_in(1, 0, 0, 0, 1, 8'h44, 32'd104);
        step("seq_fill5");
        chk("d4_occ_sat", int'(o4), 4);
        set_in(1, 1, 1, 0, 1, 8'h45, 32'd105);
        step("seq_kill");
        chk("d4_kill_occ", int'(o4), 0);
        chk("d4_kill_ctrl", int'(c4), 0);
        chk("d4_kill_data", int'(d4), 101);

        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom));
            step("rand");
        end
        tests++;
        if (max_o4 > 4) begin
            fails++;
            $display("FAIL d4_occ_bound: got %0d, want <= 4", max_o4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
